// File: rtl/matrix_cal_pkg.sv
// matrix_cal_pkg: shared constants, element/vector types and bank-state encoding for the matrix datapath
package matrix_cal_pkg;
  localparam int N = 16;
  localparam int DW_DEF = 8;
  function automatic int ew(input int dw);
    return dw + 4;
  endfunction
  localparam int EW = ew(DW_DEF);
  typedef logic [EW-1:0] elem_t;
  typedef elem_t [N-1:0] vec_t;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;
endpackage

// File: rtl/matrix_col2row_bank.sv
// matrix_col2row_bank: one NxN element store, written a column at a time and read a row at a time
module matrix_col2row_bank
  import matrix_cal_pkg::*;
#(
  parameter int W = 12
) (
  input  logic           clk,
  input  logic           we,
  input  logic [3:0]     wcol,
  input  logic [N*W-1:0] wdata,
  input  logic [3:0]     rrow,
  output logic [N*W-1:0] rdata
);
  logic [W-1:0] mem [N][N];
  // column write: element r of the incoming column lands in row r
  always_ff @(posedge clk) begin
    if (we)
      for (int r = 0; r < N; r++)
        mem[wcol][r] <= wdata[r*W +: W];
  end
  for (genvar c = 0; c < N; c++) begin : g_rd
    assign rdata[c*W +: W] = mem[c][rrow];
  end
endmodule

// File: rtl/matrix_col2row_buf.sv
// matrix_col2row_buf: ping-pong column-to-row transpose buffer; define MATRIX_COL2ROW_OUT_REG_EN for a registered skid output
module matrix_col2row_buf
  import matrix_cal_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           col_vld,
  output logic                           col_rdy,
  input  logic [N*(DATA_WIDTH+4)-1:0]    col_data,
  output logic                           row_vld,
  input  logic                           row_rdy,
  output logic [N*(DATA_WIDTH+4)-1:0]    row_data,
  output logic                           blk_done
);
  localparam int W = ew(DATA_WIDTH);
  logic [1:0] full;
  logic wr_sel, rd_sel;
  logic [3:0] wr_cnt, rd_cnt;
  logic [N*W-1:0] rdata0, rdata1, int_data;
  logic col_fire, wr_last, int_vld, int_rdy, rd_fire, rd_last;
  logic [1:0] set_full, clr_full;
  assign col_rdy = !full[wr_sel];
  assign col_fire = col_vld & col_rdy;
  assign wr_last = wr_cnt == 4'(N-1);
  assign int_vld = full[rd_sel];
  assign int_data = rd_sel ? rdata1 : rdata0;
  assign rd_fire = int_vld & int_rdy;
  assign rd_last = rd_cnt == 4'(N-1);
  assign set_full = (col_fire & wr_last) ? (wr_sel ? 2'b10 : 2'b01) : 2'b00;
  assign clr_full = (rd_fire & rd_last) ? (rd_sel ? 2'b10 : 2'b01) : 2'b00;
  matrix_col2row_bank #(.W(W)) u_bank0 (
    .clk(clk), .we(col_fire & !wr_sel), .wcol(wr_cnt), .wdata(col_data), .rrow(rd_cnt), .rdata(rdata0)
  );
  matrix_col2row_bank #(.W(W)) u_bank1 (
    .clk(clk), .we(col_fire & wr_sel), .wcol(wr_cnt), .wdata(col_data), .rrow(rd_cnt), .rdata(rdata1)
  );
  // write pointer: column index wraps after the last column and flips to the other bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_sel <= 1'b0;
      wr_cnt <= 4'd0;
    end else if (col_fire) begin
      wr_cnt <= wr_cnt + 4'd1;
      if (wr_last) wr_sel <= !wr_sel;
    end
  end
  // read pointer: row index wraps after the last row and flips to the other bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_sel <= 1'b0;
      rd_cnt <= 4'd0;
    end else if (rd_fire) begin
      rd_cnt <= rd_cnt + 4'd1;
      if (rd_last) rd_sel <= !rd_sel;
    end
  end
  // bank occupancy: set and clear always target different banks, so both may apply in one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) full <= 2'b00;
    else full <= (full | set_full) & ~clr_full;
  end
`ifdef MATRIX_COL2ROW_OUT_REG_EN
  logic ov, ol, sv, sl;
  logic [N*W-1:0] od, sd;
  assign int_rdy = !sv;
  assign row_vld = ov;
  assign row_data = od;
  assign blk_done = ov & row_rdy & ol;
  // output register control: reload when empty or consumed, otherwise park an accepted row in the skid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov <= 1'b0;
      ol <= 1'b0;
      sv <= 1'b0;
      sl <= 1'b0;
    end else if (!ov || row_rdy) begin
      ov <= sv | rd_fire;
      ol <= sv ? sl : rd_last;
      sv <= 1'b0;
    end else if (rd_fire) begin
      sv <= 1'b1;
      sl <= rd_last;
    end
  end
  // output register data path, mirrors the control above
  always_ff @(posedge clk) begin
    if (!ov || row_rdy) od <= sv ? sd : int_data;
    else if (rd_fire) sd <= int_data;
  end
`else
  assign int_rdy = row_rdy;
  assign row_vld = int_vld;
  assign row_data = int_data;
  assign blk_done = rd_fire & rd_last;
`endif
endmodule
